bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Consumes the 1 Hz square wave from the divider stage (same iClk domain) and keeps time of day as HH:MM:SS in packed BCD.
- Sits between the divider and the seven-segment / display driver.
- Supports synchronous load of a user-set time and a run/pause control.

Parameters:
- SYNC_STAGES, 2, number of flops resynchronising iTick before edge detection; legal range 1..3.
- HOUR_MAX, 23, highest hour value before the hour field wraps to 00.

Ports:
- iClk  input  1  system clock (50 MHz).
- iRst_n  input  1  reset.
- iTick  input  1  1 Hz square wave from the divider; each rising edge advances time by one second.
- iRun  input  1  1 = count, 0 = pause (ticks discarded).
- iLoad  input  1  single-cycle strobe; load iSetH/iSetM/iSetS.
- iSetH  input  8  hour, packed BCD (tens in [7:4], units in [3:0]).
- iSetM  input  8  minute, packed BCD.
- iSetS  input  8  second, packed BCD.
- oHour  output  8  current hour, packed BCD.
- oMin  output  8  current minute, packed BCD.
- oSec  output  8  current second, packed BCD.
- oSecPulse  output  1  one-cycle pulse on each accepted second increment.
- oDayPulse  output  1  one-cycle pulse when time wraps HOUR_MAX:59:59 -> 00:00:00.
- oLoadErr  output  1  one-cycle pulse when iLoad carries an invalid value.

Behaviour:
- Reset is decided: iRst_n, asynchronous, active-low; clock iClk.
- Reset (async, any time, including mid-count or mid-load): sync chain and edge-detect flop cleared to 0; oHour/oMin/oSec = 8'h00; all pulse outputs = 0.
- Edge detect: tick_edge = sync_out & ~sync_prev.
  - With SYNC_STAGES=2, if iTick is first sampled high at iClk edge k, the counters and oSecPulse update at edge k+2.
  - Fixed latency: SYNC_STAGES cycles.
- Advance happens on tick_edge when iRun=1 and iLoad=0:
  - Seconds units 9 -> 0 with carry to tens.
  - Seconds 59 -> 00 with carry into minutes.
  - Minutes 59 -> 00 with carry into hours.
  - Hours HOUR_MAX -> 00.
  - All fields carry in the same cycle; there is no ripple delay.
- oSecPulse goes high in the same cycle the new time is registered. oDayPulse goes high only in the cycle the result is 00:00:00 from a wrap.
- A tick_edge with iRun=0 is discarded, not deferred; no pulse is generated.
- Load validity check: every nibble ≤ 9, minute tens ≤ 5, second tens ≤ 5, and hour ≤ HOUR_MAX.
  - Valid: time takes the set values at the next edge. No oSecPulse or oDayPulse.
  - Invalid: time unchanged; oLoadErr = 1 for one cycle.
- iLoad and tick_edge in the same cycle: load wins and the tick is dropped. This holds even if the load is invalid.
- iLoad is honoured regardless of iRun.
- Counter state is never outside legal BCD range.

Optional Feature:
- Macro H12_MODE_EN.
- Defined:
  - Hour field counts 12, 01..11 with a registered oPm output (1 bit, reset 0). oPm toggles on the 11:59:59 -> 12:00:00 transition.
  - Reset value of the hour is 8'h12.
  - Load validity for hours becomes 01..12. oPm is not loadable and is unchanged by a load.
  - oDayPulse fires on the 11:59:59 PM -> 12:00:00 AM transition.
  - HOUR_MAX is ignored.
- Undefined: 24-hour behaviour as above; no oPm port.

Decomposition:
- Package clock_pkg:
  - BCD field width constant (8).
  - Field limits: SEC_MAX=8'h59, MIN_MAX=8'h59.
  - A function checking packed-BCD validity against a limit.
- Sub-module bcd_mod_counter:
  - Two-digit BCD counter with parameter MAX.
  - Ports: carry-in, synchronous load, carry-out (asserted when value==MAX and carry-in).
  - Instantiated three times: seconds, minutes, hours.
  - Hour wrap target and H12 handling live in the hour instance's parameters and the top level.

Test Plan:
- Reset: assert iRst_n=0 mid-count at 12:34:56 → outputs 00:00:00 immediately (asynchronous), pulses 0. After release, first iTick rising edge → 00:00:01 and one oSecPulse.
- Carry chain: load 23:59:58, iRun=1, two ticks → 23:59:59, then 00:00:00 with oDayPulse high exactly one cycle coincident with the 2nd oSecPulse.
- Latency: iTick rises at edge k → oSec changes at edge k+2 (SYNC_STAGES=2). A glitch-free 10-cycle-wide iTick high yields exactly one increment.
- Pause: iRun=0 across 3 iTick edges starting at 00:00:10 → stays 00:00:10, no oSecPulse. Set iRun=1, next tick → 00:00:11.
- Load: iSetM=8'h60 → oLoadErr one cycle, time unchanged. iLoad with iSetH=8'h07, iSetM=8'h30, iSetS=8'h00 coinciding with tick_edge → 07:30:00, no oSecPulse.
- H12_MODE_EN: load 11:59:59 with oPm=0, one tick → 12:00:00 and oPm=1. Load hour 8'h00 → oLoadErr.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared widths, field limits and the packed-BCD validity helper for the
// time-of-day counter.
`timescale 1ns/1ps
package clock_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
    localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;

    // Packed-BCD ordering matches numeric ordering once both nibbles are <= 9,
    // so a plain compare against the limit is enough after the digit check.
    function automatic logic bcdValid(input logic [BCD_W-1:0] value,
                                      input logic [BCD_W-1:0] limit);
        return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= limit);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps from MAX to WRAP and reports a
// carry-out in the cycle it wraps.
`timescale 1ns/1ps
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX     = 8'h59,
    parameter logic [BCD_W-1:0] WRAP    = 8'h00,
    parameter logic [BCD_W-1:0] RST_VAL = 8'h00
) (
    input  logic             clk_i,
    input  logic             rstN_i,
    input  logic             carry_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] loadVal_i,
    output logic [BCD_W-1:0] value_o,
    output logic             carry_o
);

    logic [BCD_W-1:0] value_q;
    logic [BCD_W-1:0] value_d;

    // Load takes priority; the caller only raises load_i for validated values.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = loadVal_i;
        end else if (carry_i) begin
            if (value_q == MAX) begin
                value_d = WRAP;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = carry_i && (value_q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS packed-BCD time-of-day counter driven by a resynchronised 1 Hz tick.
// Define H12_MODE_EN for 12-hour counting with an oPm flag.
`timescale 1ns/1ps
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MAX    = 23
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iTick,
    input  logic             iRun,
    input  logic             iLoad,
    input  logic [BCD_W-1:0] iSetH,
    input  logic [BCD_W-1:0] iSetM,
    input  logic [BCD_W-1:0] iSetS,
    output logic [BCD_W-1:0] oHour,
    output logic [BCD_W-1:0] oMin,
    output logic [BCD_W-1:0] oSec,
    output logic             oSecPulse,
    output logic             oDayPulse,
`ifdef H12_MODE_EN
    output logic             oPm,
`endif
    output logic             oLoadErr
);

`ifdef H12_MODE_EN
    localparam logic [BCD_W-1:0] HOUR_TOP  = 8'h12;
    localparam logic [BCD_W-1:0] HOUR_WRAP = 8'h01;
    localparam logic [BCD_W-1:0] HOUR_RST  = 8'h12;
`else
    localparam logic [BCD_W-1:0] HOUR_TOP  = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [BCD_W-1:0] HOUR_WRAP = 8'h00;
    localparam logic [BCD_W-1:0] HOUR_RST  = 8'h00;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncPrev_q;
    logic                   secPulse_q;
    logic                   dayPulse_q;
    logic                   loadErr_q;
    logic                   tickEdge;
    logic                   advance;
    logic                   loadValid;
    logic                   loadOk;
    logic                   secCarry;
    logic                   minCarry;
    logic                   hourCarry;
    logic                   dayWrap;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync_q     <= '0;
            syncPrev_q <= 1'b0;
        end else begin
            sync_q[0] <= iTick;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            syncPrev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tickEdge = sync_q[SYNC_STAGES-1] & ~syncPrev_q;
    assign advance  = tickEdge & iRun & ~iLoad;

`ifdef H12_MODE_EN
    assign loadValid = bcdValid(iSetS, SEC_MAX) && bcdValid(iSetM, MIN_MAX)
                    && bcdValid(iSetH, HOUR_TOP) && (iSetH != 8'h00);
`else
    assign loadValid = bcdValid(iSetS, SEC_MAX) && bcdValid(iSetM, MIN_MAX)
                    && bcdValid(iSetH, HOUR_TOP);
`endif
    assign loadOk = iLoad & loadValid;

    bcd_mod_counter #(.MAX(SEC_MAX), .WRAP(8'h00), .RST_VAL(8'h00)) uSec (
        .clk_i(iClk), .rstN_i(iRst_n), .carry_i(advance), .load_i(loadOk),
        .loadVal_i(iSetS), .value_o(oSec), .carry_o(secCarry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX), .WRAP(8'h00), .RST_VAL(8'h00)) uMin (
        .clk_i(iClk), .rstN_i(iRst_n), .carry_i(secCarry), .load_i(loadOk),
        .loadVal_i(iSetM), .value_o(oMin), .carry_o(minCarry)
    );

    bcd_mod_counter #(.MAX(HOUR_TOP), .WRAP(HOUR_WRAP), .RST_VAL(HOUR_RST)) uHour (
        .clk_i(iClk), .rstN_i(iRst_n), .carry_i(minCarry), .load_i(loadOk),
        .loadVal_i(iSetH), .value_o(oHour), .carry_o(hourCarry)
    );

`ifdef H12_MODE_EN
    logic pm_q;
    logic pmFlip;

    // 11:59:59 -> 12:00:00 flips AM/PM; the day ends only when leaving PM.
    assign pmFlip  = minCarry && (oHour == 8'h11);
    assign dayWrap = pmFlip && pm_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pm_q <= 1'b0;
        end else if (pmFlip) begin
            pm_q <= ~pm_q;
        end
    end

    assign oPm = pm_q;
`else
    assign dayWrap = hourCarry;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            secPulse_q <= 1'b0;
            dayPulse_q <= 1'b0;
            loadErr_q  <= 1'b0;
        end else begin
            secPulse_q <= advance;
            dayPulse_q <= dayWrap;
            loadErr_q  <= iLoad & ~loadValid;
        end
    end

    assign oSecPulse = secPulse_q;
    assign oDayPulse = dayPulse_q;
    assign oLoadErr  = loadErr_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: reset, carry chain, latency, pause,
// load checks and load/tick collision. H12_MODE_EN selects the 12-hour tests.
`timescale 1ns/1ps
module tb_bcd_time_counter;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iTick = 1'b0;
    logic       iRun = 1'b0;
    logic       iLoad = 1'b0;
    logic [7:0] iSetH = 8'h00;
    logic [7:0] iSetM = 8'h00;
    logic [7:0] iSetS = 8'h00;
    logic [7:0] oHour;
    logic [7:0] oMin;
    logic [7:0] oSec;
    logic       oSecPulse;
    logic       oDayPulse;
    logic       oLoadErr;
`ifdef H12_MODE_EN
    logic       oPm;
    localparam logic [7:0] RST_HOUR = 8'h12;
`else
    localparam logic [7:0] RST_HOUR = 8'h00;
`endif

    int total = 0;
    int bad = 0;
    int secCnt = 0;
    int dayCnt = 0;
    int bothCnt = 0;
    int errCnt = 0;

    bcd_time_counter dut (
        .iClk(iClk), .iRst_n(iRst_n), .iTick(iTick), .iRun(iRun), .iLoad(iLoad),
        .iSetH(iSetH), .iSetM(iSetM), .iSetS(iSetS),
        .oHour(oHour), .oMin(oMin), .oSec(oSec),
        .oSecPulse(oSecPulse), .oDayPulse(oDayPulse),
`ifdef H12_MODE_EN
        .oPm(oPm),
`endif
        .oLoadErr(oLoadErr)
    );

    always #5 iClk = ~iClk;

    // Pulse counters sampled just after each active edge.
    always @(posedge iClk) begin
        #1;
        if (oSecPulse === 1'b1) secCnt++;
        if (oDayPulse === 1'b1) dayCnt++;
        if (oSecPulse === 1'b1 && oDayPulse === 1'b1) bothCnt++;
        if (oLoadErr === 1'b1) errCnt++;
    end

    task automatic clearCounts();
        secCnt = 0; dayCnt = 0; bothCnt = 0; errCnt = 0;
    endtask

    task automatic loadTime(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge iClk);
        iSetH = h; iSetM = m; iSetS = s; iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        @(negedge iClk);
    endtask

    task automatic doTick();
        @(negedge iClk);
        iTick = 1'b1;
        repeat (4) @(negedge iClk);
        iTick = 1'b0;
        repeat (4) @(negedge iClk);
    endtask

    task automatic checkTime(input string name, input logic [23:0] exp);
        total++;
        if ({oHour, oMin, oSec} !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", name, {oHour, oMin, oSec}, exp);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        iRun = 1'b1;
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;
        loadTime(8'h12, 8'h34, 8'h56);
        checkTime("preload", 24'h123456);
        @(negedge iClk);
        iTick = 1'b1;
        @(negedge iClk);
        #2 iRst_n = 1'b0;
        #1;
        checkTime("async_reset", {RST_HOUR, 16'h0000});
        checkCount("reset_pulses", int'({oSecPulse, oDayPulse, oLoadErr}), 0);
        iTick = 1'b0;
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;
        repeat (2) @(negedge iClk);
        clearCounts();
        doTick();
        checkTime("first_tick", {RST_HOUR, 16'h0001});
        checkCount("first_tick_pulse", secCnt, 1);
    endtask

    task automatic test_carry();
        loadTime(8'h23, 8'h59, 8'h58);
        clearCounts();
        doTick();
        checkTime("carry_59", 24'h235959);
        checkCount("carry_day_early", dayCnt, 0);
        doTick();
        checkTime("carry_wrap", 24'h000000);
        checkCount("carry_sec_pulses", secCnt, 2);
        checkCount("carry_day_pulse", dayCnt, 1);
        checkCount("carry_day_with_sec", bothCnt, 1);
    endtask

    task automatic test_latency();
        loadTime(8'h01, 8'h00, 8'h00);
        clearCounts();
        @(negedge iClk);
        iTick = 1'b1;
        @(posedge iClk); #1;
        checkTime("lat_k", 24'h010000);
        @(posedge iClk); #1;
        checkTime("lat_k1", 24'h010000);
        @(posedge iClk); #1;
        checkTime("lat_k2", 24'h010001);
        repeat (7) @(posedge iClk);
        #1 iTick = 1'b0;
        repeat (5) @(negedge iClk);
        checkTime("wide_tick", 24'h010001);
        checkCount("wide_tick_pulses", secCnt, 1);
    endtask

    task automatic test_pause();
        loadTime(8'h01, 8'h00, 8'h10);
        clearCounts();
        iRun = 1'b0;
        repeat (3) doTick();
        checkTime("pause_hold", 24'h010010);
        checkCount("pause_pulses", secCnt, 0);
        iRun = 1'b1;
        doTick();
        checkTime("resume", 24'h010011);
        checkCount("resume_pulse", secCnt, 1);
    endtask

    task automatic test_load();
        clearCounts();
        loadTime(8'h01, 8'h60, 8'h00);
        checkTime("bad_min_hold", 24'h010011);
        checkCount("bad_min_err", errCnt, 1);
        clearCounts();
        loadTime(8'h24, 8'h00, 8'h00);
        checkCount("bad_hour_err", errCnt, 1);
        clearCounts();
        loadTime(8'h01, 8'h00, 8'h1A);
        checkCount("bad_nibble_err", errCnt, 1);
        checkTime("bad_nibble_hold", 24'h010011);
        clearCounts();
        loadTime(8'h12, 8'h34, 8'h56);
        checkTime("good_load", 24'h123456);
        checkCount("good_load_err", errCnt, 0);
        checkCount("good_load_pulse", secCnt + dayCnt, 0);
        iRun = 1'b0;
        clearCounts();
        loadTime(8'h10, 8'h20, 8'h30);
        checkTime("load_paused", 24'h102030);
        iRun = 1'b1;
`ifndef H12_MODE_EN
        loadTime(8'h23, 8'h00, 8'h00);
        checkTime("load_hour_max", 24'h230000);
`endif
    endtask

    task automatic test_back_to_back();
        clearCounts();
        @(negedge iClk);
        iTick = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        iSetH = 8'h07; iSetM = 8'h30; iSetS = 8'h00; iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        repeat (3) @(negedge iClk);
        iTick = 1'b0;
        repeat (3) @(negedge iClk);
        checkTime("collide_load", 24'h073000);
        checkCount("collide_pulse", secCnt, 0);
        clearCounts();
        @(negedge iClk);
        iTick = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        iSetH = 8'h01; iSetM = 8'h60; iSetS = 8'h00; iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        repeat (3) @(negedge iClk);
        iTick = 1'b0;
        repeat (3) @(negedge iClk);
        checkTime("collide_bad_hold", 24'h073000);
        checkCount("collide_bad_err", errCnt, 1);
        checkCount("collide_bad_pulse", secCnt, 0);
    endtask

`ifdef H12_MODE_EN
    task automatic test_h12();
        loadTime(8'h11, 8'h59, 8'h59);
        clearCounts();
        doTick();
        checkTime("h12_noon", 24'h120000);
        checkCount("h12_pm_set", int'(oPm), 1);
        checkCount("h12_noon_day", dayCnt, 0);
        clearCounts();
        loadTime(8'h00, 8'h00, 8'h00);
        checkCount("h12_zero_err", errCnt, 1);
        checkTime("h12_zero_hold", 24'h120000);
        loadTime(8'h12, 8'h59, 8'h59);
        doTick();
        checkTime("h12_wrap01", 24'h010000);
        loadTime(8'h11, 8'h59, 8'h59);
        checkCount("h12_pm_kept", int'(oPm), 1);
        clearCounts();
        doTick();
        checkTime("h12_midnight", 24'h120000);
        checkCount("h12_pm_clr", int'(oPm), 0);
        checkCount("h12_day", dayCnt, 1);
    endtask
`endif

    initial begin
        test_reset();
`ifdef H12_MODE_EN
        test_h12();
`else
        test_carry();
`endif
        test_latency();
        test_pause();
        test_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
